// File: rtl/pll_pkg.sv
// pll_pkg
//   Definitions shared by the PLL blocks (PhaseDetector, LoopFilter,
//   digital_oscillator) and their benches.
//   - state_t     : run state of the digitally controlled oscillator
//   - HALF_PERIOD : default nominal half-period in clock cycles
//   - MAX_STEP    : default largest correction applied to one half-period
//   - PEND_W      : default width of the signed pending-shift accumulator
package pll_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam int HALF_PERIOD = 50;
    localparam int MAX_STEP    = 4;
    localparam int PEND_W      = 6;

endpackage

// File: rtl/shift_accumulator.sv
// shift_accumulator
//   Saturating signed up/down accumulator for the oscillator's pending
//   phase shift. It also presents the pending value clamped to
//   +/-MAX_STEP, which is the correction the oscillator can apply to a
//   single half-period.
//   Ports:
//     clk_i    in   system clock
//     reset_i  in   synchronous active-low reset, clears the value
//     clear    in   forces the value to 0 at the next edge
//     inc      in   add one
//     dec      in   subtract one (inc and dec together cancel)
//     sub      in   signed amount subtracted this cycle
//     value    out  registered signed accumulator value
//     adj      out  value clamped to +/-MAX_STEP (combinational)
module shift_accumulator #(
    parameter int PEND_W   = pll_pkg::PEND_W,
    parameter int MAX_STEP = pll_pkg::MAX_STEP
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear,
    input  logic                     inc,
    input  logic                     dec,
    input  logic signed [PEND_W-1:0] sub,
    output logic signed [PEND_W-1:0] value,
    output logic signed [PEND_W-1:0] adj
);

    // One extra bit of headroom: value - sub +/- 1 can exceed the
    // PEND_W range before it is saturated.
    localparam int SUM_W = PEND_W + 1;
    localparam logic signed [SUM_W-1:0]  POS_LIMIT = SUM_W'((2 ** (PEND_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0]  NEG_LIMIT = -POS_LIMIT;
    localparam logic signed [PEND_W-1:0] POS_STEP  = PEND_W'(MAX_STEP);
    localparam logic signed [PEND_W-1:0] NEG_STEP  = -POS_STEP;

    logic signed [PEND_W-1:0] value_reg;
    logic signed [PEND_W-1:0] value_next;
    logic signed [SUM_W-1:0]  sum;

    always_comb begin
        sum = SUM_W'(value_reg) - SUM_W'(sub)
            + SUM_W'({1'b0, inc}) - SUM_W'({1'b0, dec});

        // Saturate symmetrically; the most negative code is never used so
        // the range stays +/-(2^(PEND_W-1)-1).
        if (sum > POS_LIMIT) begin
            value_next = POS_LIMIT[PEND_W-1:0];
        end else if (sum < NEG_LIMIT) begin
            value_next = NEG_LIMIT[PEND_W-1:0];
        end else begin
            value_next = sum[PEND_W-1:0];
        end

        if (clear) begin
            value_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    always_comb begin
        if (value_reg > POS_STEP) begin
            adj = POS_STEP;
        end else if (value_reg < NEG_STEP) begin
            adj = NEG_STEP;
        end else begin
            adj = value_reg;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/digital_oscillator.sv
// digital_oscillator
//   Digitally controlled oscillator closing the PLL loop. Shift pulses from
//   the loop filter are accumulated; at every half-period boundary up to
//   MAX_STEP cycles of the accumulated shift are applied, shortening the
//   next half-period for positive shift and lengthening it for negative.
//   Ports:
//     clk_i            in   system clock
//     reset_i          in   synchronous active-low reset
//     enable_i         in   run request; low stops the oscillator
//     positiveShift_i  in   one-cycle pulse, advance phase by one clock
//     negativeShift_i  in   one-cycle pulse, retard phase by one clock
//     signal_o         out  generated square wave (registered)
//     edge_o           out  one-cycle pulse in the cycle signal_o toggles
//     pending_o        out  signed shift accumulated but not yet applied
module digital_oscillator #(
    parameter int HALF_PERIOD = pll_pkg::HALF_PERIOD,
    parameter int MAX_STEP    = pll_pkg::MAX_STEP,
    parameter int PEND_W      = pll_pkg::PEND_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              positiveShift_i,
    input  logic              negativeShift_i,
    output logic              signal_o,
    output logic              edge_o,
    output logic [PEND_W-1:0] pending_o
);

    import pll_pkg::*;

    localparam int CNT_W = $clog2(HALF_PERIOD + MAX_STEP);

    state_t                   state_reg;
    state_t                   state_next;
    logic [CNT_W-1:0]         count_reg;
    logic [CNT_W-1:0]         count_next;
    logic                     signal_reg;
    logic                     signal_next;
    logic                     edge_reg;
    logic                     edge_next;

    logic                     reload;
    logic                     acc_clear;
    logic                     acc_inc;
    logic                     acc_dec;
    logic signed [PEND_W-1:0] adj;
    logic signed [PEND_W-1:0] sub_amt;
    logic signed [PEND_W-1:0] pending;
    int                       reload_val;

    // The accumulator only counts while the oscillator keeps running this
    // cycle; pulses in STOPPED or in the stopping cycle are dropped and
    // the pending value is forced back to zero.
    assign acc_inc = positiveShift_i && !acc_clear;
    assign acc_dec = negativeShift_i && !acc_clear;
    // The clamped correction is taken out of pending only on the cycle it
    // is actually applied to the counter.
    assign sub_amt = reload ? adj : '0;

    shift_accumulator #(
        .PEND_W   (PEND_W),
        .MAX_STEP (MAX_STEP)
    ) u_shift_accumulator (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear   (acc_clear),
        .inc     (acc_inc),
        .dec     (acc_dec),
        .sub     (sub_amt),
        .value   (pending),
        .adj     (adj)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_reg  <= STOPPED;
            count_reg  <= '0;
            signal_reg <= 1'b0;
            edge_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            signal_reg <= signal_next;
            edge_reg   <= edge_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        signal_next = signal_reg;
        edge_next   = 1'b0;
        reload      = 1'b0;
        acc_clear   = 1'b1;
        // A counter reload of HALF_PERIOD-1-adj yields a half-period of
        // HALF_PERIOD-adj cycles, since the zero cycle is counted too.
        reload_val  = HALF_PERIOD - 1 - int'(adj);

        case (state_reg)
            STOPPED: begin
                signal_next = 1'b0;
                count_next  = '0;
                if (enable_i) begin
                    state_next = RUNNING;
                    count_next = CNT_W'(HALF_PERIOD - 1);
                end
            end
            RUNNING: begin
                if (!enable_i) begin
                    state_next  = STOPPED;
                    signal_next = 1'b0;
                    count_next  = '0;
                end else begin
                    acc_clear = 1'b0;
                    if (count_reg == '0) begin
                        reload      = 1'b1;
                        signal_next = ~signal_reg;
                        edge_next   = 1'b1;
                        count_next  = CNT_W'(reload_val);
                    end else begin
                        count_next = count_reg - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next  = STOPPED;
                signal_next = 1'b0;
                count_next  = '0;
            end
        endcase
    end

    assign signal_o  = signal_reg;
    assign edge_o    = edge_reg;
    assign pending_o = pending;

endmodule

// File: tb/tb_digital_oscillator.sv
// tb_digital_oscillator
//   Table-driven scenarios (shift pulse pattern -> expected toggle cycles and
//   pending values) plus hand-written sequences for stop/restart and reset.
module tb_digital_oscillator;

    localparam int END_CYCLE = 230;

    logic       clk_i           = 1'b0;
    logic       reset_i         = 1'b0;
    logic       enable_i        = 1'b0;
    logic       positiveShift_i = 1'b0;
    logic       negativeShift_i = 1'b0;
    logic       signal_o;
    logic       edge_o;
    logic [5:0] pending_o;

    int checks = 0;
    int errors = 0;

    digital_oscillator dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .enable_i        (enable_i),
        .positiveShift_i (positiveShift_i),
        .negativeShift_i (negativeShift_i),
        .signal_o        (signal_o),
        .edge_o          (edge_o),
        .pending_o       (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string name;
        int    n_pos;
        int    n_neg;
        int    start;
        int    step;
        int    t1;
        int    t2;
        int    t3;
        int    t4;
        int    pend45;
        int    pend_end;
    } scen_t;

    scen_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pend();
        return int'($signed(pending_o));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i         = 1'b0;
        enable_i        = 1'b0;
        positiveShift_i = 1'b0;
        negativeShift_i = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic pulse_at(input int c, input int n, input int start, input int step);
        if (n == 0 || c < start) return 1'b0;
        if (((c - start) % step) != 0) return 1'b0;
        return ((c - start) / step) < n;
    endfunction

    task automatic run_scenario(input scen_t s);
        int  tog[4];
        int  nt;
        int  edge_err;
        int  p45;
        logic prev_sig;
        logic changed;
        nt       = 0;
        edge_err = 0;
        p45      = -99;
        prev_sig = 1'b0;
        for (int i = 0; i < 4; i++) tog[i] = -1;

        do_reset();
        reset_i  = 1'b1;
        enable_i = 1'b1;
        for (int c = 0; c <= END_CYCLE; c++) begin
            positiveShift_i = pulse_at(c, s.n_pos, s.start, s.step);
            negativeShift_i = pulse_at(c, s.n_neg, s.start, s.step);
            tick();
            changed = (signal_o != prev_sig);
            if (edge_o != changed) edge_err++;
            if (changed && nt < 4) begin
                tog[nt] = c;
                nt++;
            end
            prev_sig = signal_o;
            if (c == 45) p45 = pend();
        end
        positiveShift_i = 1'b0;
        negativeShift_i = 1'b0;

        check({s.name, " toggle1"}, tog[0], s.t1);
        check({s.name, " toggle2"}, tog[1], s.t2);
        check({s.name, " toggle3"}, tog[2], s.t3);
        check({s.name, " toggle4"}, tog[3], s.t4);
        check({s.name, " pending@45"}, p45, s.pend45);
        check({s.name, " pending@end"}, pend(), s.pend_end);
        check({s.name, " edge_vs_signal_errs"}, edge_err, 0);
        $display("scenario %s: toggles %0d %0d %0d %0d pending@45 %0d pending@end %0d",
                 s.name, tog[0], tog[1], tog[2], tog[3], p45, pend());
    endtask

    initial begin
        int  rise;
        logic prev_sig;

        //            name        npos nneg start step  t1  t2   t3   t4  p45 pend_end
        tbl[0] = '{"idle",          0,   0,   10,   1, 50, 100, 150, 200,  0,  0};
        tbl[1] = '{"pos3",          3,   0,   10,  10, 50,  97, 147, 197,  3,  0};
        tbl[2] = '{"neg10",         0,  10,   10,   2, 50, 104, 158, 210,-10,  0};
        tbl[3] = '{"cancel20",     20,  20,   10,   1, 50, 100, 150, 200,  0,  0};
        tbl[4] = '{"pos_at_reload", 1,   0,   50,   1, 50, 100, 149, 199,  0,  0};
        tbl[5] = '{"pos6",          6,   0,   10,   2, 50,  96, 144, 194,  6,  0};
        tbl[6] = '{"sat40",        40,   0,    1,   1, 50,  96, 142, 188, 31, 15};

        // Reset state
        do_reset();
        check("reset signal_o", int'(signal_o), 0);
        check("reset edge_o", int'(edge_o), 0);
        check("reset pending_o", pend(), 0);
        $display("reset: signal %0d edge %0d pending %0d", signal_o, edge_o, pend());

        for (int i = 0; i < 7; i++) begin
            run_scenario(tbl[i]);
        end

        // Enable dropped with pending = 5, then re-enabled
        do_reset();
        reset_i  = 1'b1;
        enable_i = 1'b1;
        for (int c = 0; c <= 75; c++) begin
            positiveShift_i = pulse_at(c, 5, 55, 2);
            tick();
        end
        positiveShift_i = 1'b0;
        check("pre-stop signal_o", int'(signal_o), 1);
        check("pre-stop pending_o", pend(), 5);
        enable_i        = 1'b0;
        positiveShift_i = 1'b1;
        tick();
        positiveShift_i = 1'b0;
        check("stop signal_o", int'(signal_o), 0);
        check("stop edge_o", int'(edge_o), 0);
        check("stop pending_o", pend(), 0);
        $display("stop: signal %0d edge %0d pending %0d", signal_o, edge_o, pend());
        positiveShift_i = 1'b1;
        tick();
        tick();
        positiveShift_i = 1'b0;
        check("stopped pending_o holds 0", pend(), 0);
        enable_i = 1'b1;
        tick();
        rise     = -1;
        prev_sig = signal_o;
        for (int c = 1; c <= 60 && rise < 0; c++) begin
            tick();
            if (signal_o && !prev_sig) rise = c;
            prev_sig = signal_o;
        end
        check("restart first rise", rise, 50);
        $display("restart: first rise at cycle %0d", rise);

        // Reset asserted mid-run
        do_reset();
        reset_i  = 1'b1;
        enable_i = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            positiveShift_i = (c == 55);
            tick();
        end
        positiveShift_i = 1'b0;
        check("pre-reset pending_o", pend(), 1);
        check("pre-reset signal_o", int'(signal_o), 1);
        reset_i = 1'b0;
        tick();
        check("midrun reset signal_o", int'(signal_o), 0);
        check("midrun reset edge_o", int'(edge_o), 0);
        check("midrun reset pending_o", pend(), 0);
        $display("midrun reset: signal %0d edge %0d pending %0d", signal_o, edge_o, pend());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
